// File: rtl/inference_controller_pkg.sv
// Shared types for the inference sequencer: fixed-point element, FSM states and index sizing.
package inference_controller_pkg;

  localparam int FP_W    = 16;
  localparam int FP_FRAC = 8;

  typedef logic signed [FP_W-1:0] fixed_point;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    ARGMAX,
    RESULT
  } controller_state;

  function automatic int argmax_index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/inference_controller_argmax_scanner.sv
// Sequential argmax: loads a vector on start, then compares one element per cycle.
// done marks the cycle examining the last element; index/value already include that element.
module argmax_scanner
  import inference_controller_pkg::*;
#(
  parameter int N  = 10,
  parameter int IW = argmax_index_width(N)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [N*FP_W-1:0] vector,
  output logic              done,
  output logic [IW-1:0]     index,
  output logic [FP_W-1:0]   value
);

  fixed_point    vec_q [N];
  fixed_point    best_q;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] pos_q;
  logic          active_q;

  fixed_point cand;
  logic       take;

  // Strictly-greater replacement keeps the lowest index on ties.
  always_comb begin
    cand  = vec_q[pos_q];
    take  = active_q && (cand > best_q);
    index = take ? pos_q : idx_q;
    value = take ? cand : best_q;
    done  = active_q && (pos_q == IW'(N - 1));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < N; k++) vec_q[k] <= '0;
      best_q   <= '0;
      idx_q    <= '0;
      pos_q    <= '0;
      active_q <= 1'b0;
    end else if (start) begin
      for (int k = 0; k < N; k++) vec_q[k] <= vector[k*FP_W +: FP_W];
      best_q   <= vector[FP_W-1:0];
      idx_q    <= '0;
      pos_q    <= IW'(1);
      active_q <= (N > 1);
    end else if (active_q) begin
      best_q <= value;
      idx_q  <= index;
      pos_q  <= pos_q + 1'b1;
      if (done) active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/inference_controller.sv
// Host-side sequencer for the neural_network datapath: capture, launch, watchdog wait,
// argmax scan and result handshake; one frame in flight, no input buffering.
module inference_controller
  import inference_controller_pkg::*;
#(
  parameter  int NUM_INPUTS     = 10,
  parameter  int NUM_OUTPUTS    = 10,
  parameter  int TIMEOUT_CYCLES = 4096,
  localparam int IW             = argmax_index_width(NUM_OUTPUTS),
  localparam int WDW            = $clog2(TIMEOUT_CYCLES)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_INPUTS*FP_W-1:0]    in_data,
  output logic [NUM_INPUTS*FP_W-1:0]    nn_inputs,
  output logic                          nn_inputs_ready,
  input  logic [NUM_OUTPUTS*FP_W-1:0]   nn_outputs,
  input  logic                          nn_outputs_ready,
  output logic                          result_valid,
  input  logic                          result_ready,
  output logic [IW-1:0]                 result_class,
  output logic [FP_W-1:0]               result_score,
  output logic                          result_timeout,
  output logic                          busy,
  output logic [15:0]                   frame_count
);

  controller_state               state_q;
  logic                          in_ready_q;
  logic [NUM_INPUTS*FP_W-1:0]    nn_inputs_q;
  logic                          launch_q;
  logic [WDW-1:0]                wd_q;
  logic                          result_valid_q;
  logic [IW-1:0]                 result_class_q;
  logic [FP_W-1:0]               result_score_q;
  logic                          result_timeout_q;
  logic [15:0]                   frame_count_q;

  logic            scan_start;
  logic            scan_done;
  logic [IW-1:0]   scan_index;
  logic [FP_W-1:0] scan_value;

  assign scan_start = (state_q == WAIT) && nn_outputs_ready;

  argmax_scanner #(
    .N  (NUM_OUTPUTS),
    .IW (IW)
  ) u_scanner (
    .clock  (clock),
    .reset  (reset),
    .start  (scan_start),
    .vector (nn_outputs),
    .done   (scan_done),
    .index  (scan_index),
    .value  (scan_value)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q          <= IDLE;
      in_ready_q       <= 1'b0;
      nn_inputs_q      <= '0;
      launch_q         <= 1'b0;
      wd_q             <= '0;
      result_valid_q   <= 1'b0;
      result_class_q   <= '0;
      result_score_q   <= '0;
      result_timeout_q <= 1'b0;
      frame_count_q    <= '0;
    end else begin
      launch_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            nn_inputs_q <= in_data;
            in_ready_q  <= 1'b0;
            launch_q    <= 1'b1;
            state_q     <= LAUNCH;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        LAUNCH: begin
          wd_q    <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          wd_q <= wd_q + 1'b1;
          // Completion wins over a watchdog expiry in the same cycle.
          if (nn_outputs_ready) begin
            if (NUM_OUTPUTS > 1) begin
              state_q <= ARGMAX;
            end else begin
              result_valid_q   <= 1'b1;
              result_timeout_q <= 1'b0;
              result_class_q   <= '0;
              result_score_q   <= nn_outputs[FP_W-1:0];
              state_q          <= RESULT;
            end
          end else if (wd_q == WDW'(TIMEOUT_CYCLES - 1)) begin
            result_valid_q   <= 1'b1;
            result_timeout_q <= 1'b1;
            result_class_q   <= '0;
            result_score_q   <= '0;
            state_q          <= RESULT;
          end
        end
        ARGMAX: begin
          if (scan_done) begin
            result_valid_q   <= 1'b1;
            result_timeout_q <= 1'b0;
            result_class_q   <= scan_index;
            result_score_q   <= scan_value;
            state_q          <= RESULT;
          end
        end
        RESULT: begin
          if (result_ready) begin
            result_valid_q <= 1'b0;
            frame_count_q  <= frame_count_q + 16'd1;
            in_ready_q     <= 1'b1;
            state_q        <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready        = in_ready_q;
  assign nn_inputs       = nn_inputs_q;
  assign nn_inputs_ready = launch_q;
  assign result_valid    = result_valid_q;
  assign result_class    = result_class_q;
  assign result_score    = result_score_q;
  assign result_timeout  = result_timeout_q;
  assign busy            = (state_q != IDLE);
  assign frame_count     = frame_count_q;

endmodule

// File: tb/tb_inference_controller.sv
// Randomized frames against a cycle-level reference of the sequencer's timing and argmax rules.
module tb_inference_controller;
  import inference_controller_pkg::*;

  localparam int NI = 10;
  localparam int NO = 10;
  localparam int TO = 16;
  localparam int IW = argmax_index_width(NO);

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [NI*FP_W-1:0]   in_data = '0;
  logic [NI*FP_W-1:0]   nn_inputs;
  logic                 nn_inputs_ready;
  logic [NO*FP_W-1:0]   nn_outputs = '0;
  logic                 nn_outputs_ready = 1'b0;
  logic                 result_valid;
  logic                 result_ready = 1'b0;
  logic [IW-1:0]        result_class;
  logic [FP_W-1:0]      result_score;
  logic                 result_timeout;
  logic                 busy;
  logic [15:0]          frame_count;

  int n_tests = 0;
  int n_fail  = 0;
  int launches = 0;

  fixed_point cur_out [NO];
  longint     last_cls;
  longint     last_sc;
  longint     last_to;

  inference_controller #(
    .NUM_INPUTS     (NI),
    .NUM_OUTPUTS    (NO),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_data          (in_data),
    .nn_inputs        (nn_inputs),
    .nn_inputs_ready  (nn_inputs_ready),
    .nn_outputs       (nn_outputs),
    .nn_outputs_ready (nn_outputs_ready),
    .result_valid     (result_valid),
    .result_ready     (result_ready),
    .result_class     (result_class),
    .result_score     (result_score),
    .result_timeout   (result_timeout),
    .busy             (busy),
    .frame_count      (frame_count)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (reset && nn_inputs_ready === 1'b1) launches <= launches + 1;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: highest value wins, earliest position among equals.
  task automatic ref_argmax(output int cls, output fixed_point sc);
    fixed_point mx;
    mx = cur_out[0];
    foreach (cur_out[i]) if (cur_out[i] > mx) mx = cur_out[i];
    cls = -1;
    foreach (cur_out[i]) if (cls < 0 && cur_out[i] == mx) cls = i;
    sc = mx;
  endtask

  function automatic logic [NO*FP_W-1:0] pack_out();
    logic [NO*FP_W-1:0] p;
    for (int i = 0; i < NO; i++) p[i*FP_W +: FP_W] = cur_out[i];
    return p;
  endfunction

  function automatic logic [NO*FP_W-1:0] garbage();
    logic [NO*FP_W-1:0] p;
    for (int i = 0; i < NO; i++) p[i*FP_W +: FP_W] = FP_W'($urandom);
    return p;
  endfunction

  task automatic rand_out();
    for (int i = 0; i < NO; i++) cur_out[i] = fixed_point'((int'($urandom_range(0, 15)) - 8) * 256);
  endtask

  task automatic set_out(input int v0, v1, v2, v3, v4, v5, v6, v7, v8, v9);
    int t [NO];
    t = '{v0, v1, v2, v3, v4, v5, v6, v7, v8, v9};
    for (int i = 0; i < NO; i++) cur_out[i] = fixed_point'(t[i] * 256);
  endtask

  task automatic chk_reset_vals();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_launch", nn_inputs_ready, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_timeout", result_timeout, 0);
    chk("rst_class", result_class, 0);
    chk("rst_score", result_score, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_nn_inputs_zero", nn_inputs == '0, 1);
    chk("rst_busy", busy, 0);
  endtask

  // Entered and left at a falling edge. comp_dly<0 means no completion (watchdog path).
  task automatic run_frame(input int comp_dly, input int hold, input bit keep_valid, input bit late);
    logic [NI*FP_W-1:0] din;
    int comp_k, exp_rise, rise, late_k, fc0, wk, exp_cls;
    fixed_point exp_sc;
    logic exp_to;
    bit stable_in, stable_res;
    for (int i = 0; i < NI; i++) din[i*FP_W +: FP_W] = FP_W'($urandom);
    in_data  = din;
    in_valid = 1'b1;
    wk = 0;
    while (in_ready !== 1'b1 && wk < 50) begin @(negedge clock); wk++; end
    if (in_ready !== 1'b1) begin
      chk("in_ready_wait", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    fc0 = int'(frame_count);
    if (comp_dly >= 0) begin
      ref_argmax(exp_cls, exp_sc);
      comp_k = 2 + comp_dly; exp_rise = comp_k + NO; exp_to = 1'b0;
    end else begin
      exp_cls = 0; exp_sc = '0; comp_k = -1; exp_rise = 2 + TO; exp_to = 1'b1;
    end
    late_k = late ? exp_rise + 3 : -1;
    rise = -1; stable_in = 1'b1; stable_res = 1'b1;
    for (int k = 1; k < exp_rise + hold + 20; k++) begin
      @(negedge clock);
      if (k == 1) begin
        chk("launch_pulse", nn_inputs_ready, 1);
        if (!keep_valid) in_valid = 1'b0;
      end
      if (k == 2) chk("launch_width", nn_inputs_ready, 0);
      if (rise < 0) begin
        if (k > 1 && nn_inputs_ready !== 1'b0) stable_in = 1'b0;
        if (nn_inputs !== din || in_ready !== 1'b0 || busy !== 1'b1) stable_in = 1'b0;
        if (result_valid === 1'b1) begin
          rise = k;
          last_cls = longint'(result_class);
          last_sc  = longint'(fixed_point'(result_score));
          last_to  = longint'(result_timeout);
          chk("valid_latency", k, exp_rise);
          chk("class", result_class, exp_cls);
          chk("score", fixed_point'(result_score), exp_sc);
          chk("timeout", result_timeout, exp_to);
        end
      end else if (k <= rise + hold) begin
        if (result_valid !== 1'b1 || in_ready !== 1'b0 || result_class !== IW'(exp_cls) ||
            fixed_point'(result_score) !== exp_sc || result_timeout !== exp_to ||
            frame_count !== 16'(fc0))
          stable_res = 1'b0;
      end else begin
        result_ready = 1'b0;
        chk("in_ready_after_hs", in_ready, 1);
        chk("busy_after_hs", busy, 0);
        chk("frame_count", frame_count, (fc0 + 1) & 16'hffff);
        break;
      end
      nn_outputs_ready = (k == comp_k) || (k == late_k);
      nn_outputs       = (k == comp_k) ? pack_out() : garbage();
      if (rise >= 0 && k == rise + hold) result_ready = 1'b1;
    end
    nn_outputs_ready = 1'b0;
    result_ready     = 1'b0;
    if (rise < 0) chk("result_valid_seen", result_valid, 1);
    chk("inputs_stable", stable_in, 1);
    chk("result_stable", stable_res, 1);
  endtask

  initial begin
    int l0, d, h;
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    chk_reset_vals();
    reset = 1'b1;
    #1 chk("in_ready_before_edge", in_ready, 0);
    @(negedge clock);
    chk("in_ready_rise", in_ready, 1);

    // Five frames with in_valid held high the whole time.
    l0 = launches;
    for (int f = 0; f < 5; f++) begin
      rand_out();
      run_frame(int'($urandom_range(0, TO - 1)), int'($urandom_range(0, 3)), 1'b1, 1'b0);
    end
    in_valid = 1'b0;
    chk("frames_after_5", frame_count, 5);
    chk("launches_after_5", launches - l0, 5);

    set_out(1, 3, -2, 7, 0, 5, 7, 2, 1, 0);
    run_frame(int'($urandom_range(0, 5)), 20, 1'b0, 1'b0);
    chk("dir_class", last_cls, 3);
    chk("dir_score", last_sc, 7 * 256);

    set_out(-4, -1, -9, -3, -5, -1, -7, -2, -8, -1);
    run_frame(3, 2, 1'b0, 1'b0);
    chk("neg_class", last_cls, 1);
    chk("neg_score", last_sc, -256);

    rand_out();
    run_frame(-1, 8, 1'b0, 1'b1);
    chk("to_flag", last_to, 1);
    chk("to_class", last_cls, 0);
    chk("to_score", last_sc, 0);

    rand_out();
    run_frame(TO - 1, 1, 1'b0, 1'b0);
    chk("late_completion_not_timeout", last_to, 0);

    for (int f = 0; f < 30; f++) begin
      rand_out();
      d = ($urandom_range(0, 6) == 0) ? -1 : int'($urandom_range(0, TO - 1));
      h = int'($urandom_range(0, 7));
      run_frame(d, h, 1'($urandom_range(0, 1)), (h >= 5));
    end
    in_valid = 1'b0;

    // Reset in the middle of WAIT.
    rand_out();
    in_data  = garbage();
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (3) @(negedge clock);
    chk("mid_busy_before_reset", busy, 1);
    reset = 1'b0;
    #1 chk_reset_vals();
    @(negedge clock);
    chk_reset_vals();
    reset = 1'b1;
    #1 chk("mid_in_ready_pre", in_ready, 0);
    @(negedge clock);
    chk("mid_in_ready_rise", in_ready, 1);
    run_frame(int'($urandom_range(0, TO - 1)), 1, 1'b0, 1'b0);
    chk("mid_frame_count", frame_count, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
